// File: rtl/sb_to_queue_buf_sim.sv
// Multi-channel valid/ready bridge into switchboard TX queues, one elastic FIFO per channel.
// The switchboard init/send calls are modelled in-module so the bridge runs standalone.
`timescale 1ns/1ps
module sb_to_queue_buf_sim #(
   parameter int DW                 = 416,
   parameter int NCH                = 1,
   parameter int DEPTH              = 4,
   parameter int READY_MODE_DEFAULT = 0,
   parameter int DROP_UNCONNECTED   = 0,
   parameter int LW                 = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH*DW-1:0] data,
   input  logic [NCH*32-1:0] dest,
   input  logic [NCH-1:0]    last,
   input  logic [NCH-1:0]    valid,
   output logic [NCH-1:0]    ready,
   output logic [NCH*LW-1:0] level,
   output logic [NCH*32-1:0] drop_count
);
   localparam int PW   = DW + 33;
   localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SBW  = 6;
   localparam int SBQ  = 1 << SBW;
   localparam int LOGN = 256;

   logic [PW-1:0]   mem    [NCH][DEPTH];
   logic [PTRW-1:0] rd_ptr [NCH];
   logic [PTRW-1:0] wr_ptr [NCH];
   logic [LW-1:0]   cnt    [NCH];
   logic [31:0]     drops  [NCH];

   int    id [NCH]   = '{default: -1};
   int    ready_mode = READY_MODE_DEFAULT;
   int    next_sid   = 0;
   logic  sb_accept [SBQ] = '{default: 1'b1};
   int    sb_width  [SBQ];
   string sb_uri    [SBQ];

   // Record of every packet the queues accepted, in send order.
   int            send_calls = 0;
   int            log_cnt    = 0;
   logic [31:0]   log_dest [LOGN];
   logic [DW-1:0] log_data [LOGN];

   task automatic pi_sb_tx_init(output int sid, input string uri, input int width);
      sid = next_sid;
      sb_uri[next_sid[SBW-1:0]]   = uri;
      sb_width[next_sid[SBW-1:0]] = width;
      next_sid = next_sid + 1;
   endtask

   task automatic init(input int ch, input string uri);
      int sid;
      pi_sb_tx_init(sid, uri, DW / 8);
      id[ch] = sid;
   endtask

   task automatic set_ready_mode(input int value);
      ready_mode = value;
   endtask

   task automatic set_queue_accept(input int sid, input logic en);
      sb_accept[sid[SBW-1:0]] = en;
   endtask

   // Nonzero when the queue behind sid takes the packet this cycle.
   function automatic int pi_sb_send(input int sid);
      if (sid < 0 || sid >= next_sid) return 0;
      if (sb_uri[sid[SBW-1:0]] == "" || sb_width[sid[SBW-1:0]] != DW / 8) return 0;
      return sb_accept[sid[SBW-1:0]] ? 1 : 0;
   endfunction

   function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
      return (int'(p) == DEPTH - 1) ? '0 : p + PTRW'(1);
   endfunction

   always_ff @(posedge clk) begin
      int            calls;
      int            n;
      logic          pop;
      logic          push;
      logic          space;
      logic [LW-1:0] nxt;
      calls = send_calls;
      n     = log_cnt;
      if (reset) begin
         for (int ch = 0; ch < NCH; ch++) begin
            rd_ptr[ch] <= '0;
            wr_ptr[ch] <= '0;
            cnt[ch]    <= '0;
            drops[ch]  <= '0;
            ready[ch]  <= 1'b0;
         end
      end else begin
         for (int ch = 0; ch < NCH; ch++) begin
            pop  = 1'b0;
            push = ready[ch] & valid[ch];
            if (cnt[ch] != '0) begin
               if (id[ch] != -1) begin
                  calls = calls + 1;
                  if (pi_sb_send(id[ch]) != 0) begin
                     pop = 1'b1;
                     log_dest[n[7:0]] <= mem[ch][rd_ptr[ch]][32:1];
                     log_data[n[7:0]] <= mem[ch][rd_ptr[ch]][PW-1:33];
                     n = n + 1;
                  end
               end else if (DROP_UNCONNECTED != 0) begin
                  pop = 1'b1;
                  if (drops[ch] != '1) drops[ch] <= drops[ch] + 32'd1;
               end
            end
            if (push) begin
               mem[ch][wr_ptr[ch]] <= {data[ch*DW +: DW], dest[ch*32 +: 32], last[ch]};
               wr_ptr[ch] <= ptr_inc(wr_ptr[ch]);
            end
            if (pop) rd_ptr[ch] <= ptr_inc(rd_ptr[ch]);
            nxt   = cnt[ch] + LW'(push) - LW'(pop);
            space = (int'(nxt) < DEPTH);
            cnt[ch] <= nxt;
            case (ready_mode)
               0:       ready[ch] <= valid[ch] & ~push & space;
               2:       ready[ch] <= space & (($random & 32'sd1) != 0);
               default: ready[ch] <= space;
            endcase
         end
      end
      send_calls <= calls;
      log_cnt    <= n;
   end

   for (genvar g = 0; g < NCH; g++) begin : g_out
      assign level[g*LW +: LW]      = cnt[g];
      assign drop_count[g*32 +: 32] = drops[g];
   end
endmodule
